sc_update_queue: RTL and testbench

SC_UPDATE_QUEUE -- requirements
Module: sc_update_queue

---
 rtl/sc_update_queue_if.sv | 29 ++
 rtl/sc_update_queue.sv | 89 ++++++++
 tb/tb_sc_update_queue.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/sc_update_queue_if.sv
// sc_update_queue_if: commit-side update requests in, SC table writes out.
interface sc_update_queue_if #(
    parameter int DEPTH     = 4,
    parameter int IDX_WIDTH = 8,
    parameter int CTR_WIDTH = 6,
    parameter int SLOT_NUM  = 2
);
    logic                          in_valid;
    logic                          in_ready;
    logic [IDX_WIDTH-1:0]          in_idx;
    logic [SLOT_NUM-1:0]           in_slot_en;
    logic [SLOT_NUM-1:0]           in_taken;
    logic [SLOT_NUM*CTR_WIDTH-1:0] in_ctr;
    logic                          out_valid;
    logic                          out_ready;
    logic [IDX_WIDTH-1:0]          out_idx;
    logic [SLOT_NUM*CTR_WIDTH-1:0] out_ctr;
    logic [SLOT_NUM-1:0]           out_slot_en;
    logic [$clog2(DEPTH):0]        count;

    modport master (
        output in_valid, in_idx, in_slot_en, in_taken, in_ctr, out_ready,
        input  in_ready, out_valid, out_idx, out_ctr, out_slot_en, count
    );
    modport slave (
        input  in_valid, in_idx, in_slot_en, in_taken, in_ctr, out_ready,
        output in_ready, out_valid, out_idx, out_ctr, out_slot_en, count
    );
endinterface

// File: rtl/sc_update_queue.sv
// sc_update_queue: FIFO of SC counter updates with youngest-match forwarding
// so back-to-back updates to one index accumulate before reaching the table.
module sc_update_queue #(
    parameter int DEPTH     = 4,
    parameter int IDX_WIDTH = 8,
    parameter int CTR_WIDTH = 6,
    parameter int SLOT_NUM  = 2
) (
    input logic              clk,
    input logic              rst,
    sc_update_queue_if.slave q
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = SLOT_NUM * CTR_WIDTH;
    typedef logic signed [CTR_WIDTH-1:0] ctr_t;
    localparam ctr_t CMAX = {1'b0, {(CTR_WIDTH-1){1'b1}}};
    localparam ctr_t CMIN = {1'b1, {(CTR_WIDTH-1){1'b0}}};

    logic [IDX_WIDTH-1:0] idx_q [DEPTH];
    logic [IDX_WIDTH-1:0] idx_d [DEPTH];
    logic [DW-1:0]        ctr_q [DEPTH];
    logic [DW-1:0]        ctr_d [DEPTH];
    logic [SLOT_NUM-1:0]  en_q  [DEPTH];
    logic [SLOT_NUM-1:0]  en_d  [DEPTH];
    logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 enq, deq;
    logic [DW-1:0]        base_ctr, new_ctr;
    logic [SLOT_NUM-1:0]  base_en;
    ctr_t                 b;

    assign q.in_ready    = count_q < CW'(DEPTH);
    assign q.out_valid   = count_q != '0;
    assign q.out_idx     = idx_q[head_q];
    assign q.out_ctr     = ctr_q[head_q];
    assign q.out_slot_en = en_q[head_q];
    assign q.count       = count_q;

    always_comb begin
        enq      = q.in_valid && q.in_ready && |q.in_slot_en;
        deq      = q.out_valid && q.out_ready;
        base_ctr = q.in_ctr;
        base_en  = '0;
        b        = '0;
        new_ctr  = '0;
        // Scan oldest to youngest so the last hit is the most recent entry.
        for (int k = 0; k < DEPTH; k++)
            if (CW'(k) < count_q && idx_q[head_q + PW'(k)] == q.in_idx) begin
                base_ctr = ctr_q[head_q + PW'(k)];
                base_en  = en_q[head_q + PW'(k)];
            end
        for (int i = 0; i < SLOT_NUM; i++) begin
            b = base_ctr[i*CTR_WIDTH +: CTR_WIDTH];
            new_ctr[i*CTR_WIDTH +: CTR_WIDTH] = !q.in_slot_en[i] ? b :
                q.in_taken[i] ? (b == CMAX ? b : b + ctr_t'(1)) :
                                (b == CMIN ? b : b - ctr_t'(1));
        end
        idx_d = idx_q;
        ctr_d = ctr_q;
        en_d  = en_q;
        if (enq) begin
            idx_d[tail_q] = q.in_idx;
            ctr_d[tail_q] = new_ctr;
            en_d[tail_q]  = q.in_slot_en | base_en;
        end
        head_d  = head_q + PW'(deq);
        tail_d  = tail_q + PW'(enq);
        count_d = count_q + CW'(enq) - CW'(deq);
    end

    always_ff @(posedge clk) begin
        idx_q <= idx_d;
        ctr_q <= ctr_d;
        en_q  <= en_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_sc_update_queue.sv
// tb_sc_update_queue: directed scenarios for sc_update_queue, inputs driven and
// outputs sampled on the falling edge.
module tb_sc_update_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    sc_update_queue_if #(.DEPTH(4), .IDX_WIDTH(8), .CTR_WIDTH(6), .SLOT_NUM(2)) bus ();
    sc_update_queue #(.DEPTH(4), .IDX_WIDTH(8), .CTR_WIDTH(6), .SLOT_NUM(2)) dut (
        .clk(clk), .rst(rst), .q(bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [7:0] idx, input logic [1:0] en,
                         input logic [1:0] tk, input logic [11:0] ctr, input logic ordy);
        bus.in_valid   = v;
        bus.in_idx     = idx;
        bus.in_slot_en = en;
        bus.in_taken   = tk;
        bus.in_ctr     = ctr;
        bus.out_ready  = ordy;
    endtask

    task automatic test_reset;
        drive(0, 8'h00, 2'b00, 2'b00, 12'h000, 0);
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL post_reset count=%0d valid=%b exp 0/0", bus.count, bus.out_valid); end
    endtask

    task automatic test_single;
        drive(1, 8'h12, 2'b01, 2'b01, {6'd3, 6'd5}, 0);
        @(negedge clk);
        drive(0, 8'h00, 2'b00, 2'b00, 12'h000, 0);
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", bus.out_valid); end
        total++; if (bus.out_idx !== 8'h12) begin bad++; $display("FAIL single_idx got=%h exp=12", bus.out_idx); end
        total++; if (bus.out_ctr !== {6'd3, 6'd6}) begin bad++; $display("FAIL single_ctr got=%h exp=%h", bus.out_ctr, {6'd3, 6'd6}); end
        total++; if (bus.out_slot_en !== 2'b01) begin bad++; $display("FAIL single_en got=%b exp=01", bus.out_slot_en); end
        total++; if (bus.count !== 3'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", bus.count); end
        drive(0, 8'h00, 2'b00, 2'b00, 12'h000, 1);
        @(negedge clk);
        total++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_drain count=%0d valid=%b exp 0/0", bus.count, bus.out_valid); end
        drive(1, 8'h13, 2'b00, 2'b11, 12'h000, 0);
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL discard_ready got=%b exp=1", bus.in_ready); end
        @(negedge clk);
        drive(0, 8'h00, 2'b00, 2'b00, 12'h000, 0);
        total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL discard_count got=%0d exp=0", bus.count); end
    endtask

    task automatic test_saturation;
        drive(1, 8'h20, 2'b01, 2'b01, {6'd0, 6'd31}, 0);
        @(negedge clk);
        total++; if (bus.out_ctr !== {6'd0, 6'd31}) begin bad++; $display("FAIL sat_max got=%h exp=%h", bus.out_ctr, {6'd0, 6'd31}); end
        drive(1, 8'h21, 2'b01, 2'b00, {6'd0, 6'h20}, 1);
        @(negedge clk);
        total++; if (bus.count !== 3'd1 || bus.out_idx !== 8'h21) begin bad++; $display("FAIL sat_swap count=%0d idx=%h exp 1/21", bus.count, bus.out_idx); end
        total++; if (bus.out_ctr !== {6'd0, 6'h20}) begin bad++; $display("FAIL sat_min got=%h exp=%h", bus.out_ctr, {6'd0, 6'h20}); end
        drive(1, 8'h22, 2'b10, 2'b00, {6'd9, 6'd0}, 1);
        @(negedge clk);
        total++; if (bus.out_ctr !== {6'd8, 6'd0}) begin bad++; $display("FAIL dec_slot1 got=%h exp=%h", bus.out_ctr, {6'd8, 6'd0}); end
        drive(0, 8'h00, 2'b00, 2'b00, 12'h000, 1);
        @(negedge clk);
        total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL sat_drain got=%0d exp=0", bus.count); end
    endtask

    task automatic test_forward;
        logic [7:0]  ei [3] = '{8'h40, 8'h40, 8'h41};
        logic [11:0] ec [3] = '{{6'h3f, 6'd1}, {6'h3f, 6'd2}, {6'd4, 6'd8}};
        logic [1:0]  ee [3] = '{2'b11, 2'b11, 2'b01};
        drive(1, 8'h40, 2'b11, 2'b01, 12'h000, 0);
        @(negedge clk);
        drive(1, 8'h40, 2'b01, 2'b01, 12'h000, 0);
        @(negedge clk);
        drive(1, 8'h41, 2'b01, 2'b01, {6'd4, 6'd7}, 0);
        @(negedge clk);
        drive(0, 8'h00, 2'b00, 2'b00, 12'h000, 1);
        total++; if (bus.count !== 3'd3) begin bad++; $display("FAIL fwd_count got=%0d exp=3", bus.count); end
        for (int n = 0; n < 3; n++) begin
            total++; if (bus.out_idx !== ei[n]) begin bad++; $display("FAIL fwd_idx[%0d] got=%h exp=%h", n, bus.out_idx, ei[n]); end
            total++; if (bus.out_ctr !== ec[n]) begin bad++; $display("FAIL fwd_ctr[%0d] got=%h exp=%h", n, bus.out_ctr, ec[n]); end
            total++; if (bus.out_slot_en !== ee[n]) begin bad++; $display("FAIL fwd_en[%0d] got=%b exp=%b", n, bus.out_slot_en, ee[n]); end
            @(negedge clk);
        end
        total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL fwd_drain got=%0d exp=0", bus.count); end
    endtask

    task automatic test_full;
        logic [7:0] ei [4] = '{8'h51, 8'h52, 8'h53, 8'h60};
        for (int i = 0; i < 4; i++) begin
            drive(1, 8'(8'h50 + i), 2'b01, 2'b01, 12'h000, 0);
            @(negedge clk);
        end
        drive(1, 8'h60, 2'b01, 2'b01, 12'h000, 0);
        total++; if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL full count=%0d ready=%b exp 4/0", bus.count, bus.in_ready); end
        @(negedge clk);
        total++; if (bus.count !== 3'd4 || bus.out_idx !== 8'h50) begin bad++; $display("FAIL full_hold count=%0d idx=%h exp 4/50", bus.count, bus.out_idx); end
        drive(1, 8'h60, 2'b01, 2'b01, 12'h000, 1);
        @(negedge clk);
        total++; if (bus.count !== 3'd3 || bus.in_ready !== 1'b1 || bus.out_idx !== 8'h51) begin bad++; $display("FAIL full_deq count=%0d ready=%b idx=%h exp 3/1/51", bus.count, bus.in_ready, bus.out_idx); end
        drive(1, 8'h60, 2'b01, 2'b01, 12'h000, 0);
        @(negedge clk);
        total++; if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL full_accept count=%0d ready=%b exp 4/0", bus.count, bus.in_ready); end
        drive(0, 8'h00, 2'b00, 2'b00, 12'h000, 1);
        for (int n = 0; n < 4; n++) begin
            total++; if (bus.out_idx !== ei[n] || bus.out_ctr !== {6'd0, 6'd1}) begin bad++; $display("FAIL full_order[%0d] idx=%h ctr=%h exp %h/001", n, bus.out_idx, bus.out_ctr, ei[n]); end
            @(negedge clk);
        end
        total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL full_drain got=%0d exp=0", bus.count); end
    endtask

    task automatic test_back_to_back;
        drive(1, 8'h70, 2'b01, 2'b01, {6'd0, 6'd0}, 0);
        @(negedge clk);
        drive(1, 8'h71, 2'b01, 2'b01, {6'd0, 6'd1}, 0);
        @(negedge clk);
        for (int c = 0; c < 8; c++) begin
            drive(1, 8'(8'h72 + c), 2'b01, 2'b01, {6'd0, 6'(c + 2)}, 1);
            total++; if (bus.out_idx !== 8'(8'h70 + c) || bus.out_ctr !== {6'd0, 6'(c + 1)}) begin bad++; $display("FAIL b2b_head[%0d] idx=%h ctr=%h exp %h/%h", c, bus.out_idx, bus.out_ctr, 8'(8'h70 + c), {6'd0, 6'(c + 1)}); end
            @(negedge clk);
            total++; if (bus.count !== 3'd2) begin bad++; $display("FAIL b2b_count[%0d] got=%0d exp=2", c, bus.count); end
        end
        drive(0, 8'h00, 2'b00, 2'b00, 12'h000, 1);
        for (int c = 8; c < 10; c++) begin
            total++; if (bus.out_idx !== 8'(8'h70 + c) || bus.out_ctr !== {6'd0, 6'(c + 1)}) begin bad++; $display("FAIL b2b_tail[%0d] idx=%h ctr=%h exp %h/%h", c, bus.out_idx, bus.out_ctr, 8'(8'h70 + c), {6'd0, 6'(c + 1)}); end
            @(negedge clk);
        end
        total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL b2b_drain got=%0d exp=0", bus.count); end
    endtask

    task automatic test_fwd_head;
        drive(1, 8'h33, 2'b01, 2'b01, {6'd0, 6'd10}, 0);
        @(negedge clk);
        drive(1, 8'h33, 2'b01, 2'b01, 12'h000, 1);
        @(negedge clk);
        drive(0, 8'h00, 2'b00, 2'b00, 12'h000, 0);
        total++; if (bus.count !== 3'd1 || bus.out_idx !== 8'h33) begin bad++; $display("FAIL head_fwd count=%0d idx=%h exp 1/33", bus.count, bus.out_idx); end
        total++; if (bus.out_ctr !== {6'd0, 6'd12}) begin bad++; $display("FAIL head_fwd_ctr got=%h exp=%h", bus.out_ctr, {6'd0, 6'd12}); end
        drive(0, 8'h00, 2'b00, 2'b00, 12'h000, 1);
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'(8'h80 + i), 2'b01, 2'b01, {6'd0, 6'd20}, 0);
            @(negedge clk);
        end
        drive(0, 8'h00, 2'b00, 2'b00, 12'h000, 0);
        total++; if (bus.count !== 3'd3) begin bad++; $display("FAIL rstmid_pre got=%0d exp=3", bus.count); end
        #2 rst = 1'b1;
        #1;
        total++; if (bus.out_valid !== 1'b0 || bus.count !== 3'd0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL rstmid valid=%b count=%0d ready=%b exp 0/0/1", bus.out_valid, bus.count, bus.in_ready); end
        @(negedge clk);
        rst = 1'b0;
        drive(1, 8'h80, 2'b01, 2'b01, 12'h000, 0);
        @(negedge clk);
        drive(0, 8'h00, 2'b00, 2'b00, 12'h000, 0);
        total++; if (bus.count !== 3'd1 || bus.out_idx !== 8'h80 || bus.out_ctr !== {6'd0, 6'd1}) begin bad++; $display("FAIL rstmid_stale count=%0d idx=%h ctr=%h exp 1/80/001", bus.count, bus.out_idx, bus.out_ctr); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_saturation;
        test_forward;
        test_full;
        test_back_to_back;
        test_fwd_head;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
